uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side counterpart of the UART transmit path: samples the serial_rxd pin with the shared baud_x4 strobe from uart_clk, deframes 8N1 characters, and queues them in a small FIFO for a downstream command parser. It sits between the board pin and any consumer of host-to-FPGA bytes, driven by the same 12 MHz clock and reset as the transmit chain.

## Interface
- FIFO_DEPTH, 4, number of queued bytes; power of two, minimum 2 (used only with the FIFO compiled in)
- clk  in  1  system clock, 12 MHz
- reset  in  1  asynchronous, active-high; clears all state
- baud_x4  in  1  one-clk strobe at 4x baud rate, from uart_clk
- serial_rx  in  1  raw asynchronous RX pin, idle high
- data  out  8  head byte; 8'h00 at reset and whenever empty
- data_valid  out  1  head byte present; 0 at reset
- data_ready  in  1  consumer accepts head when data_valid=1
- frame_err  out  1  one-clk pulse, stop bit sampled low; 0 at reset
- overrun  out  1  one-clk pulse, completed byte dropped because storage full; 0 at reset

## Operation
- serial_rx passes through a 2-flop synchronizer; both flops reset to 1.
- All bit timing advances only on clk edges where baud_x4=1 (a "tick"). tick_cnt is 2 bits; bit_cnt is 3 bits.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- IDLE: on a tick with synced rx=0 -> START, tick_cnt=0.
- START: on the next tick (mid start bit), rx=1 -> IDLE (glitch rejected, nothing reported); rx=0 -> DATA, tick_cnt=0, bit_cnt=0.
- DATA: tick_cnt counts ticks; sample on tick_cnt wrap from 3 to 0 (4 ticks per bit). Sampled bits shift in LSB first. After bit 7 -> STOP.
- STOP: sample after 4 ticks. rx=1 -> push byte, -> IDLE. rx=0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
- WAIT_HIGH: on a tick with rx=1 -> IDLE. A break condition (line held low) therefore yields exactly one frame_err.
- Pop happens when data_valid & data_ready are both 1 on a clk edge. data_ready while empty is ignored.
- Push while full and no pop on the same edge: byte dropped, overrun pulse, contents unchanged.
- Push and pop on the same edge while full: both take effect, no overrun.
- Push and pop on the same edge with one entry: head replaced by the new byte, data_valid stays 1.
- Pointers are log2(FIFO_DEPTH)+1 bits. Full = MSBs differ and the remaining bits are equal; empty = pointers equal. Wrap-around is natural modulo 2*FIFO_DEPTH.
- Reset asserted mid-frame or with queued data: FSM -> IDLE, FIFO emptied, pulses cleared, synchronizer back to 1.

## Timing
- Start-edge detection uncertainty is 1 tick, so each sample lands 1-2 ticks into its 4-tick bit.
- data_valid rises on the clk edge after the stop-bit sample tick. A byte is visible about 9.5 bit times after its start edge.
- frame_err and overrun assert for exactly one clk, on the edge after the stop-bit sample tick.
- data and data_valid are registered outputs. data changes only on push-into-empty or on pop.
- Throughput: back-to-back frames with a single stop bit are received without loss while the FIFO is not full.

## Configuration
- UART_RX_FIFO_EN defined: FIFO of FIFO_DEPTH entries, as described above.
- UART_RX_FIFO_EN undefined: single holding register. Full = data_valid. Push, pop, overrun and simultaneous-event rules are identical with depth 1. FIFO_DEPTH is ignored.

## Structure
- Shared include misc/uart_defs.vh holds the FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4, 3 bits), TICKS_PER_BIT=4 and DATA_BITS=8. The transmit side uses the same constants.
- One sub-module, uart_byte_fifo (clk, reset, push, push_data, pop, head, empty, full), parameterized by depth. The single-register variant is implemented by the same sub-module at depth 1 under the macro.

## Test plan
- Send 0x55 then 0xA3 at 4 ticks per bit with baud_x4 every 26 clk, data_ready=1 -> data_valid pulses twice with data=0x55 then 0xA3, no frame_err or overrun.
- Drive a 1-tick low glitch on serial_rx -> no data_valid, no frame_err, FSM returns to IDLE.
- Send 0x41 with the stop bit low, then hold the line low for 20 bit times -> exactly one frame_err pulse, nothing queued, next valid 0x42 is received correctly.
- data_ready=0, send FIFO_DEPTH+1 bytes 0x01, 0x02, ... -> one overrun on the last byte; drain yields 0x01..0x04 in order, then data_valid=0.
- With the FIFO full, assert data_ready on the exact edge a new byte 0x7E is pushed -> no overrun, 0x7E is read last.
- Assert reset during bit 4 of a frame with 2 bytes queued -> data_valid=0, data=0x00 immediately; the following frame 0x99 is received cleanly.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and the receive FSM state type for the UART receive path.
// The values match the transmit side: 8N1 framing, 4 ticks of baud_x4 per bit.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam int TICKS_PER_BIT = 4;
    localparam int DATA_BITS     = 8;

    // Last tick of a bit period and last data-bit index, at counter widths
    localparam logic [1:0] TICK_LAST = 2'(TICKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte queue with registered head/empty outputs. Head reads 8'h00 while empty.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a counter. DEPTH=1 degenerates to a single holding register.
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_rd_idx_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_head;
    logic [7:0]    w_head_nxt;
    logic          r_empty;
    logic          w_pop;
    logic          w_push;

    // Storage index is the pointer without its wrap bit; a single slot is always index 0
    generate
        if (DEPTH > 1) begin : g_idx
            assign w_wr_idx     = r_wr_ptr[AW-1:0];
            assign w_rd_idx     = r_rd_ptr[AW-1:0];
            assign w_rd_idx_nxt = w_rd_ptr_nxt[AW-1:0];
        end else begin : g_idx_single
            assign w_wr_idx     = '0;
            assign w_rd_idx     = '0;
            assign w_rd_idx_nxt = '0;
        end
    endgenerate

    assign full   = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) && (w_wr_idx == w_rd_idx);
    assign w_pop  = pop & ~r_empty;
    // A pop on the same edge frees the slot, so a push into a full queue still lands
    assign w_push = push & (~full | w_pop);

    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);

    assign head  = r_head;
    assign empty = r_empty;

    // Next head: zero when the queue will be empty, the incoming byte when it becomes the only entry
    always_comb begin
        w_head_nxt = r_head;
        if (w_wr_ptr_nxt == w_rd_ptr_nxt) begin
            w_head_nxt = 8'h00;
        end else if (w_push && (w_wr_idx == w_rd_idx_nxt)) begin
            w_head_nxt = push_data;
        end else begin
            w_head_nxt = r_mem[w_rd_idx_nxt];
        end
    end

    // Byte storage write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    // Pointers and registered head/empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= 8'h00;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_head   <= w_head_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchronizes serial_rx, deframes on baud_x4 ticks
// (4 per bit, sample on the 4th tick of each bit) and queues bytes for a
// consumer with a valid/ready handshake.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry queue; without
// it a single holding register is used and FIFO_DEPTH has no effect.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_x4,
    input  logic       serial_rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun
);

`ifdef UART_RX_FIFO_EN
    localparam int STORE_DEPTH = FIFO_DEPTH;
`else
    // Single holding register regardless of FIFO_DEPTH
    localparam int STORE_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

    logic       r_rx_meta;
    logic       r_rx_sync;
    rx_state_e  r_state;
    rx_state_e  w_state_nxt;
    logic [1:0] r_tick_cnt;
    logic [1:0] w_tick_cnt_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       w_push;
    logic       w_frame_err;
    logic       w_overrun;
    logic       r_frame_err;
    logic       r_overrun;
    logic [7:0] w_head;
    logic       w_empty;
    logic       w_full;

    // Two-flop synchronizer for the asynchronous pin, idle level 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= serial_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Deframer state, counters and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= 2'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    // Deframer next state; everything advances only on baud ticks
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_push         = 1'b0;
        w_frame_err    = 1'b0;
        if (baud_x4) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_sync) begin
                        w_state_nxt    = ST_START;
                        w_tick_cnt_nxt = 2'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_START: begin
                    // Start bit must still be low one tick later, else it was a glitch
                    if (r_rx_sync) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt    = ST_DATA;
                        w_tick_cnt_nxt = 2'd0;
                        w_bit_cnt_nxt  = 3'd0;
                    end
                end
                ST_DATA: begin
                    w_tick_cnt_nxt = r_tick_cnt + 2'd1;
                    if (r_tick_cnt == TICK_LAST) begin
                        w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end else begin
                        w_shift_nxt = r_shift;
                    end
                end
                ST_STOP: begin
                    w_tick_cnt_nxt = r_tick_cnt + 2'd1;
                    if (r_tick_cnt == TICK_LAST) begin
                        if (r_rx_sync) begin
                            w_push      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_frame_err = 1'b1;
                            w_state_nxt = ST_WAIT_HIGH;
                        end
                    end else begin
                        w_state_nxt = ST_STOP;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line (break) reports once, then waits for idle
                    if (r_rx_sync) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT_HIGH;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // A completed byte is lost only if storage is full and nothing leaves on the same edge
    assign w_overrun = w_push & w_full & ~(data_ready & ~w_empty);

    // One-clock status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;
        end
    end

    uart_byte_fifo #(
        .DEPTH(STORE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (data_ready),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign data       = w_head;
    assign data_valid = ~w_empty;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frame table, hand-written
// corner sequences (glitch, break, overrun, pop-on-push while full, reset
// mid-frame) and randomized bursts checked against a queue model.
module tb_uart_rx_fifo;

    localparam int BAUD_DIV = 26;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct {
        logic [7:0] tx;
        logic       stop_ok;
        int         gap_bits;
        int         exp_n;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_x4;
    logic       serial_rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         div_cnt  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_x4    (baud_x4),
        .serial_rx  (serial_rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // baud_x4: one clk high every BAUD_DIV clks, changed just after posedge
    initial begin
        baud_x4 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div_cnt = (div_cnt == BAUD_DIV - 1) ? 0 : div_cnt + 1;
            baud_x4 = (div_cnt == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: collects popped bytes and pulse counts; empty head must read zero
    always @(negedge clk) begin
        if (data_valid && data_ready) got_q.push_back(data);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (!data_valid) check("empty_data_zero", data, 0);
    end

    task automatic wait_tick();
        do @(posedge clk); while (baud_x4 !== 1'b1);
    endtask

    // Must be called right at a tick edge; holds each bit for 4 ticks.
    // With pop_at_push, data_ready is high only for the clk ending on the
    // stop-sample tick (2nd tick of the stop bit, given the 1-tick sync lag).
    task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                              input int gap_bits, input logic pop_at_push);
        logic [8:0] fr;
        fr = {b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            #1 serial_rx = fr[i];
            repeat (4) wait_tick();
        end
        #1 serial_rx = stop_ok;
        if (pop_at_push) begin
            wait_tick();
            repeat (BAUD_DIV - 1) @(posedge clk);
            #1 data_ready = 1'b1;
            @(posedge clk);
            #1 data_ready = 1'b0;
            repeat (2) wait_tick();
        end else begin
            repeat (4) wait_tick();
        end
        if (gap_bits > 0) begin
            #1 serial_rx = 1'b1;
            repeat (4 * gap_bits) wait_tick();
        end
    endtask

    task automatic check_drain(input string name, input int base);
        check({name, "_count"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check($sformatf("%s_byte%0d", name, i), got_q[base + i], exp_q[i]);
        end
    endtask

    initial begin
        vec_t       vecs[8];
        int         base, f0, o0, n, ferr_exp, ovr_exp;
        logic [7:0] b;
        logic       ok;
        logic [8:0] fr;

        vecs[0] = '{8'h55, 1'b1, 0, 1, 8'h55, 0};
        vecs[1] = '{8'hA3, 1'b1, 1, 1, 8'hA3, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 1, 8'h00, 0};
        vecs[3] = '{8'hFF, 1'b1, 0, 1, 8'hFF, 0};
        vecs[4] = '{8'h80, 1'b1, 1, 1, 8'h80, 0};
        vecs[5] = '{8'h3C, 1'b0, 2, 0, 8'h00, 1};
        vecs[6] = '{8'h01, 1'b1, 1, 1, 8'h01, 0};
        vecs[7] = '{8'hC5, 1'b1, 1, 1, 8'hC5, 0};

        reset = 1'b1; serial_rx = 1'b1; data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", data_valid, 0);
        check("reset_data", data, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        reset = 1'b0;
        repeat (4) wait_tick();

        // Directed frames, consumer always ready
        #1 data_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            base = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[v].tx, vecs[v].stop_ok, vecs[v].gap_bits, 1'b0);
            check($sformatf("vec%0d_count", v), got_q.size() - base, vecs[v].exp_n);
            if (vecs[v].exp_n > 0 && got_q.size() > base)
                check($sformatf("vec%0d_byte", v), got_q[got_q.size() - 1], vecs[v].exp_byte);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 0);
        end

        // One-tick low glitch is rejected silently
        base = got_q.size(); f0 = ferr_cnt;
        wait_tick();
        repeat (BAUD_DIV - 10) @(posedge clk);
        #1 serial_rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 serial_rx = 1'b1;
        repeat (8) wait_tick();
        check("glitch_count", got_q.size() - base, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        send_frame(8'h5A, 1'b1, 1, 1'b0);
        exp_q = {8'h5A};
        check_drain("after_glitch", base);

        // Bad stop bit followed by a long break: exactly one frame error
        base = got_q.size(); f0 = ferr_cnt;
        send_frame(8'h41, 1'b0, 0, 1'b0);
        repeat (80) wait_tick();
        #1 serial_rx = 1'b1;
        repeat (8) wait_tick();
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_count", got_q.size() - base, 0);
        send_frame(8'h42, 1'b1, 1, 1'b0);
        exp_q = {8'h42};
        check_drain("after_break", base);
        check("after_break_ferr", ferr_cnt - f0, 1);

        // Overrun: DEPTH+1 bytes with no consumer
        #1 data_ready = 1'b0;
        base = got_q.size(); o0 = ovr_cnt;
        exp_q = {};
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b1, 1, 1'b0);
            if (i <= DEPTH) exp_q.push_back(8'(i));
            check($sformatf("ovr_step%0d", i), ovr_cnt - o0, (i > DEPTH) ? 1 : 0);
        end
        check("full_valid", data_valid, 1);
        check("full_head", data, 8'h01);
        #1 data_ready = 1'b1;
        repeat (4) wait_tick();
        check_drain("ovr_drain", base);
        @(negedge clk);
        check("drained_valid", data_valid, 0);
        check("drained_data", data, 0);

        // Full queue, pop on the exact push edge: no overrun, new byte last
        wait_tick();
        #1 data_ready = 1'b0;
        base = got_q.size(); o0 = ovr_cnt;
        exp_q = {};
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1, 1, 1'b0);
            exp_q.push_back(8'h10 + 8'(i));
        end
        send_frame(8'h7E, 1'b1, 1, 1'b1);
        exp_q.push_back(8'h7E);
        check("pushpop_ovr", ovr_cnt - o0, 0);
        #1 data_ready = 1'b1;
        repeat (4) wait_tick();
        check_drain("pushpop_drain", base);

        // Reset during bit 4 with bytes queued
        #1 data_ready = 1'b0;
        for (int i = 0; i < ((DEPTH < 2) ? DEPTH : 2); i++)
            send_frame(8'hA0 + 8'(i), 1'b1, 1, 1'b0);
        check("prereset_valid", data_valid, 1);
        check("prereset_head", data, 8'hA0);
        fr = {8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            #1 serial_rx = fr[i];
            repeat (4) wait_tick();
        end
        #1 serial_rx = fr[5];
        repeat (2) wait_tick();
        #1 reset = 1'b1; serial_rx = 1'b1;
        #1;
        check("midreset_valid", data_valid, 0);
        check("midreset_data", data, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) wait_tick();
        base = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        #1 data_ready = 1'b1;
        send_frame(8'h99, 1'b1, 1, 1'b0);
        exp_q = {8'h99};
        check_drain("postreset", base);
        check("postreset_ferr", ferr_cnt - f0, 0);
        check("postreset_ovr", ovr_cnt - o0, 0);

        // Random bursts against a queue model; last phase keeps the consumer ready
        for (int ph = 0; ph < 3; ph++) begin
            #1 data_ready = (ph == 2);
            base = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
            exp_q = {}; ferr_exp = 0; ovr_exp = 0;
            n = $urandom_range(DEPTH + 2, 1);
            for (int j = 0; j < n; j++) begin
                b  = 8'($urandom_range(255, 0));
                ok = ($urandom_range(4, 0) != 0);
                send_frame(b, ok, 1, 1'b0);
                if (!ok) ferr_exp++;
                else if (ph == 2 || exp_q.size() < DEPTH) exp_q.push_back(b);
                else ovr_exp++;
            end
            #1 data_ready = 1'b1;
            repeat (4) wait_tick();
            check_drain($sformatf("rand%0d", ph), base);
            check($sformatf("rand%0d_ferr", ph), ferr_cnt - f0, ferr_exp);
            check($sformatf("rand%0d_ovr", ph), ovr_cnt - o0, ovr_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
